// File: rtl/q_servo_pwm.sv
// Multi-channel hobby-servo PWM generator. Software commits a clamped pending
// set; it is applied (optionally slew-limited) only at frame boundaries.
module q_servo_pwm #(
   parameter int N_CH         = 12,
   parameter int CLK_DIV      = 100,
   parameter int PERIOD_US    = 20000,
   parameter int PULSE_MIN_US = 500,
   parameter int PULSE_MAX_US = 2500,
   parameter int CENTER_US    = 1500,
   parameter int SLEW_US      = 0
) (
   input  logic                 s_axi_aclk,
   input  logic                 s_axi_aresetn,
   input  logic [N_CH*16-1:0]   cfg_pulse_us,
   input  logic [N_CH-1:0]      cfg_enable,
   input  logic                 cfg_update,
   output logic [N_CH-1:0]      pwm_out,
   output logic                 frame_start,
   output logic                 update_pending,
   output logic [15:0]          frame_cnt,
   output logic [N_CH*16-1:0]   active_pulse_us
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [15:0]   PCNT_LAST  = 16'(PERIOD_US - 1);
   localparam logic [15:0]   W_MIN      = 16'(PULSE_MIN_US);
   localparam logic [15:0]   W_MAX      = 16'(PULSE_MAX_US);
   localparam logic [15:0]   W_CTR      = 16'(CENTER_US);
   localparam logic [15:0]   W_SLEW     = 16'(SLEW_US);
   localparam logic [16:0]   W_SLEW17   = 17'(SLEW_US);

   // A clamped width must always end inside its own frame.
   if (PULSE_MAX_US >= PERIOD_US) begin : g_bad_period
      $error("q_servo_pwm: PULSE_MAX_US must be smaller than PERIOD_US");
   end
   if (PULSE_MIN_US > PULSE_MAX_US) begin : g_bad_clamp
      $error("q_servo_pwm: PULSE_MIN_US must not exceed PULSE_MAX_US");
   end

   logic [PW-1:0]         r_presc;
   logic [15:0]           r_pcnt;
   logic [15:0]           r_frame_cnt;
   logic                  r_frame_start;
   logic                  r_upd_pend;
   logic [N_CH-1:0]       r_pwm;
   logic [N_CH-1:0]       r_pend_en;
   logic [N_CH-1:0]       r_act_en;
   logic [N_CH-1:0][15:0] r_pend_w;
   logic [N_CH-1:0][15:0] r_act_w;

   logic                  w_tick;
   logic                  w_boundary;
   logic                  w_load;
   logic                  w_all_eq;
   logic [PW-1:0]         w_presc_nxt;
   logic [15:0]           w_pcnt_nxt;
   logic [N_CH-1:0][15:0] w_clamp_w;
   logic [N_CH-1:0][15:0] w_slew_w;
   logic [N_CH-1:0][15:0] w_act_w_nxt;
   logic [N_CH-1:0]       w_act_en_nxt;
   logic [N_CH-1:0]       w_pwm_nxt;

   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_boundary  = w_tick && (r_pcnt == PCNT_LAST);
   assign w_load      = w_boundary && r_upd_pend;
   assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;

   always_comb begin
      w_pcnt_nxt = r_pcnt;
      if (w_boundary)
         w_pcnt_nxt = '0;
      else if (w_tick)
         w_pcnt_nxt = r_pcnt + 16'd1;
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_clamp_w[i] = cfg_pulse_us[16*i +: 16];
         if (cfg_pulse_us[16*i +: 16] < W_MIN)
            w_clamp_w[i] = W_MIN;
         else if (cfg_pulse_us[16*i +: 16] > W_MAX)
            w_clamp_w[i] = W_MAX;
      end
   end

   // Step toward pending by at most W_SLEW; widths are <= 16 bits so the
   // 17-bit sums cannot overflow.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_slew_w[i] = r_pend_w[i];
         if (SLEW_US > 0) begin
            if ({1'b0, r_pend_w[i]} > ({1'b0, r_act_w[i]} + W_SLEW17))
               w_slew_w[i] = r_act_w[i] + W_SLEW;
            else if ({1'b0, r_act_w[i]} > ({1'b0, r_pend_w[i]} + W_SLEW17))
               w_slew_w[i] = r_act_w[i] - W_SLEW;
         end
      end
   end

   assign w_all_eq     = (w_slew_w == r_pend_w);
   assign w_act_w_nxt  = w_load ? w_slew_w  : r_act_w;
   assign w_act_en_nxt = w_load ? r_pend_en : r_act_en;

   // Output is computed from next-cycle state so the registered pin lines up
   // with the counter value it belongs to.
   always_comb begin
      for (int i = 0; i < N_CH; i++)
         w_pwm_nxt[i] = w_act_en_nxt[i] && (w_pcnt_nxt < w_act_w_nxt[i]);
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_presc       <= '0;
         r_pcnt        <= '0;
         r_frame_cnt   <= '0;
         r_frame_start <= 1'b0;
         r_upd_pend    <= 1'b0;
         r_pwm         <= '0;
         r_pend_en     <= '0;
         r_act_en      <= '0;
         r_pend_w      <= {N_CH{W_CTR}};
         r_act_w       <= {N_CH{W_CTR}};
      end else begin
         r_presc       <= w_presc_nxt;
         r_pcnt        <= w_pcnt_nxt;
         r_frame_start <= w_boundary;
         r_pwm         <= w_pwm_nxt;
         r_act_w       <= w_act_w_nxt;
         r_act_en      <= w_act_en_nxt;
         if (w_boundary)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         // A strobe coinciding with a boundary still lands in pending.
         if (cfg_update) begin
            r_pend_w   <= w_clamp_w;
            r_pend_en  <= cfg_enable;
            r_upd_pend <= 1'b1;
         end else if (w_load && w_all_eq) begin
            r_upd_pend <= 1'b0;
         end
      end
   end

   assign pwm_out         = r_pwm;
   assign frame_start     = r_frame_start;
   assign update_pending  = r_upd_pend;
   assign frame_cnt       = r_frame_cnt;
   assign active_pulse_us = r_act_w;

endmodule

// File: tb/tb_q_servo_pwm.sv
// Bench for q_servo_pwm with scaled-down timing; a plain-arithmetic model
// predicts active widths and measured high times frame by frame.
module tb_q_servo_pwm;

   localparam int NC    = 12;
   localparam int CD    = 3;
   localparam int PER   = 300;
   localparam int PMIN  = 50;
   localparam int PMAX  = 250;
   localparam int CTR   = 150;
   localparam int SLEW  = 20;
   localparam int VW    = NC * 16;
   localparam int FRAME = CD * PER;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [VW-1:0] cfg_pulse, s_cfg_pulse;
   logic [NC-1:0] cfg_en, s_cfg_en;
   logic          cfg_upd, s_cfg_upd;
   logic [NC-1:0] pwm, s_pwm;
   logic          fs, s_fs, upd, s_upd;
   logic [15:0]   fcnt, s_fcnt;
   logic [VW-1:0] act, s_act;

   q_servo_pwm #(.N_CH(NC), .CLK_DIV(CD), .PERIOD_US(PER), .PULSE_MIN_US(PMIN),
                 .PULSE_MAX_US(PMAX), .CENTER_US(CTR), .SLEW_US(0)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .cfg_pulse_us(cfg_pulse),
      .cfg_enable(cfg_en), .cfg_update(cfg_upd), .pwm_out(pwm), .frame_start(fs),
      .update_pending(upd), .frame_cnt(fcnt), .active_pulse_us(act));

   q_servo_pwm #(.N_CH(NC), .CLK_DIV(CD), .PERIOD_US(PER), .PULSE_MIN_US(PMIN),
                 .PULSE_MAX_US(PMAX), .CENTER_US(CTR), .SLEW_US(SLEW)) dut_s (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .cfg_pulse_us(s_cfg_pulse),
      .cfg_enable(s_cfg_en), .cfg_update(s_cfg_upd), .pwm_out(s_pwm), .frame_start(s_fs),
      .update_pending(s_upd), .frame_cnt(s_fcnt), .active_pulse_us(s_act));

   int n_chk  = 0;
   int n_fail = 0;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // High-time measurement: meas[] holds the previous complete frame.
   int hcnt[NC], meas[NC];
   int s_hcnt = 0, s_meas = 0;
   bit main_any_hi = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) hcnt[i] = 0;
         s_hcnt = 0;
         main_any_hi = 1'b0;
      end else begin
         if (pwm != '0) main_any_hi = 1'b1;
         for (int i = 0; i < NC; i++) begin
            if (fs) begin
               meas[i] = hcnt[i];
               hcnt[i] = int'(pwm[i]);
            end else begin
               hcnt[i] += int'(pwm[i]);
            end
         end
         if (s_fs) begin
            s_meas = s_hcnt;
            s_hcnt = int'(s_pwm[0]);
         end else begin
            s_hcnt += int'(s_pwm[0]);
         end
      end
   end

   // Reference model
   int            ref_pw[NC], ref_aw[NC], prev_aw[NC];
   logic [NC-1:0] ref_pen, ref_aen, prev_aen;
   bit            ref_upd;
   logic [15:0]   ref_fcnt;
   int            s_pw, s_aw, s_prev_aw;
   bit            s_pen, s_en, s_prev_en, s_upd_ref;
   longint        fs_cyc, rel_cyc, last_cyc, target;
   logic [VW-1:0] w;

   function automatic int clamp(input int x);
      return (x < PMIN) ? PMIN : ((x > PMAX) ? PMAX : x);
   endfunction

   function automatic logic [VW-1:0] pack_act();
      logic [VW-1:0] v;
      for (int i = 0; i < NC; i++) v[16*i +: 16] = 16'(ref_aw[i]);
      return v;
   endfunction

   function automatic logic [VW-1:0] pack_slew();
      logic [VW-1:0] v;
      v = {NC{16'(CTR)}};
      v[15:0] = 16'(s_aw);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         ref_pw[i] = CTR; ref_aw[i] = CTR; prev_aw[i] = CTR;
      end
      ref_pen = '0; ref_aen = '0; prev_aen = '0; ref_upd = 1'b0; ref_fcnt = '0;
      s_pw = CTR; s_aw = CTR; s_prev_aw = CTR;
      s_pen = 1'b0; s_en = 1'b0; s_prev_en = 1'b0; s_upd_ref = 1'b0;
   endtask

   task automatic model_boundary();
      int d;
      prev_aw = ref_aw; prev_aen = ref_aen;
      if (ref_upd) begin
         ref_aw = ref_pw; ref_aen = ref_pen; ref_upd = 1'b0;
      end
      ref_fcnt = ref_fcnt + 16'd1;
      s_prev_aw = s_aw; s_prev_en = s_en;
      if (s_upd_ref) begin
         d = s_pw - s_aw;
         if (d > SLEW) s_aw = s_aw + SLEW;
         else if (d < -SLEW) s_aw = s_aw - SLEW;
         else s_aw = s_pw;
         s_en = s_pen;
         s_upd_ref = (s_aw != s_pw);
      end
   endtask

   task automatic model_commit(input logic [VW-1:0] wv, input logic [NC-1:0] en);
      for (int i = 0; i < NC; i++) ref_pw[i] = clamp(int'(wv[16*i +: 16]));
      ref_pen = en;
      ref_upd = 1'b1;
   endtask

   task automatic wait_fs();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
         @(negedge clk); #1;
         seen = fs;
      end
      chk("fs_seen", VW'(seen), VW'(1));
      fs_cyc = cyc;
      model_boundary();
      chk("fcnt", VW'(fcnt), VW'(ref_fcnt));
   endtask

   task automatic commit(input logic [VW-1:0] wv, input logic [NC-1:0] en);
      cfg_pulse = wv; cfg_en = en; cfg_upd = 1'b1;
      @(negedge clk); #1;
      cfg_upd = 1'b0;
      model_commit(wv, en);
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_act"}, act, pack_act());
      for (int i = 0; i < NC; i++)
         chk($sformatf("%s_hi%0d", tag, i), VW'(meas[i]),
             VW'(prev_aen[i] ? prev_aw[i] * CD : 0));
   endtask

   initial begin
      cfg_pulse = {NC{16'(CTR)}}; cfg_en = '0; cfg_upd = 1'b0;
      s_cfg_pulse = {NC{16'(CTR)}}; s_cfg_en = '0; s_cfg_upd = 1'b0;
      model_reset();

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pwm", VW'(pwm), VW'(0));
      chk("rst_fs", VW'(fs), VW'(0));
      chk("rst_upd", VW'(upd), VW'(0));
      chk("rst_fcnt", VW'(fcnt), VW'(0));
      chk("rst_act", act, pack_act());

      // three idle frames on the main channel; slew commit on the second DUT
      rst_n = 1'b1;
      rel_cyc = cyc;
      last_cyc = rel_cyc;
      s_cfg_pulse[15:0] = 16'd210; s_cfg_en = 12'h001; s_cfg_upd = 1'b1;
      @(negedge clk); #1;
      s_cfg_upd = 1'b0;
      s_pw = 210; s_pen = 1'b1; s_upd_ref = 1'b1;
      chk("s_upd_set", VW'(s_upd), VW'(1));
      for (int f = 1; f <= 3; f++) begin
         wait_fs();
         chk($sformatf("period%0d", f), VW'(fs_cyc - last_cyc), VW'(FRAME));
         last_cyc = fs_cyc;
         chk($sformatf("s_act%0d", f), s_act, pack_slew());
         chk($sformatf("s_upd%0d", f), VW'(s_upd), VW'(s_upd_ref));
         chk($sformatf("s_hi%0d", f), VW'(s_meas), VW'(s_prev_en ? s_prev_aw * CD : 0));
         chk($sformatf("s_fcnt%0d", f), VW'(s_fcnt), VW'(ref_fcnt));
      end
      chk("idle_no_pwm", VW'(main_any_hi), VW'(0));

      // basic commit on ch0
      w = {NC{16'(CTR)}}; w[15:0] = 16'd100;
      commit(w, 12'h001);
      chk("c1_upd_set", VW'(upd), VW'(1));
      wait_fs();
      chk("c1_upd_clr", VW'(upd), VW'(ref_upd));
      check_frame("c1a");
      chk("s_hi4", VW'(s_meas), VW'(s_prev_en ? s_prev_aw * CD : 0));
      chk("s_upd4", VW'(s_upd), VW'(s_upd_ref));
      wait_fs();
      check_frame("c1b");

      // clamping at both ends
      w[15:0] = 16'd100; w[31:16] = 16'd10; w[47:32] = 16'd900;
      commit(w, 12'h006);
      wait_fs();
      check_frame("clamp_a");
      wait_fs();
      check_frame("clamp_b");

      // strobe coinciding with the boundary cycle
      w = {NC{16'(CTR)}}; w[15:0] = 16'd100;
      commit(w, 12'h001);
      target = fs_cyc + FRAME - 1;
      for (int k = 0; k < 2 * FRAME && cyc != target; k++) @(negedge clk);
      #1;
      chk("coll_align", VW'(cyc), VW'(target));
      w[15:0] = 16'd200;
      cfg_pulse = w; cfg_upd = 1'b1;
      @(negedge clk); #1;
      cfg_upd = 1'b0;
      chk("coll_fs", VW'(fs), VW'(1));
      fs_cyc = cyc;
      model_boundary();
      model_commit(w, 12'h001);
      chk("coll_upd", VW'(upd), VW'(1));
      check_frame("coll_a");
      wait_fs();
      check_frame("coll_b");
      wait_fs();
      check_frame("coll_c");

      // randomized commits, some repeated before the boundary
      for (int it = 0; it < 4; it++) begin
         repeat ($urandom_range(5, 700)) @(negedge clk);
         #1;
         for (int i = 0; i < NC; i++)
            w[16*i +: 16] = (i == NC - 1) ? 16'($urandom()) : 16'($urandom_range(0, 400));
         commit(w, 12'($urandom()));
         if (it % 2 == 1) begin
            for (int i = 0; i < NC; i++) w[16*i +: 16] = 16'($urandom_range(0, 400));
            commit(w, 12'($urandom()));
         end
         wait_fs();
         check_frame($sformatf("rnd%0d_a", it));
         wait_fs();
         check_frame($sformatf("rnd%0d_b", it));
      end

      // frame counter wrap from a preloaded value
      repeat (100) @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.r_frame_cnt;
      #1;
      ref_fcnt = 16'hFFFE;
      wait_fs();
      chk("wrap_ffff", VW'(fcnt), VW'(16'hFFFF));
      wait_fs();
      chk("wrap_zero", VW'(fcnt), VW'(0));

      // reset in the middle of a pulse
      w = {NC{16'(CTR)}}; w[15:0] = 16'd200;
      commit(w, 12'h001);
      wait_fs();
      repeat (20) @(negedge clk);
      #1;
      chk("pre_rst_hi", VW'(pwm[0]), VW'(ref_aen[0]));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_pwm", VW'(pwm), VW'(0));
      chk("mid_rst_act", act, pack_act());
      chk("mid_rst_upd", VW'(upd), VW'(0));
      chk("mid_rst_fcnt", VW'(fcnt), VW'(0));
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      rel_cyc = cyc;
      wait_fs();
      chk("post_rst_period", VW'(fs_cyc - rel_cyc), VW'(FRAME));
      check_frame("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
